// File: rtl/joybus_pkg.sv
// Shared types and constants for the Joybus controller command transmitter.
// Holds the FSM state type, the standard command words and the length check.
package joybus_pkg;

   typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

   localparam int unsigned JB_MAX_BITS = 24;

   localparam logic [23:0] JB_CMD_ID          = 24'h000000;
   localparam logic [4:0]  JB_LEN_ID          = 5'd8;
   localparam logic [23:0] JB_CMD_POLL        = 24'h400300;
   localparam logic [4:0]  JB_LEN_POLL        = 5'd24;
   localparam logic [23:0] JB_CMD_POLL_RUMBLE = 24'h400301;
   localparam logic [4:0]  JB_LEN_POLL_RUMBLE = 5'd24;

   function automatic logic len_ok(input logic [4:0] len);
      return (len != 5'd0) && (len <= 5'(JB_MAX_BITS));
   endfunction

endpackage

// File: rtl/joybus_bit_timer.sv
// Bit-cell timer: tracks the phase inside a 4U-cycle data cell or a U-cycle stop cell.
// low_phase is the line level wanted for the following cycle, so the caller can register it.
module joybus_bit_timer #(
   parameter int unsigned CLK_PER_US = 50,
   localparam int unsigned CW = $clog2(4 * CLK_PER_US)
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   input  logic bit_val,
   input  logic stop,
   output logic low_phase,
   output logic cell_end
);

   localparam logic [CW-1:0] LAST_CELL  = CW'(4 * CLK_PER_US - 1);
   localparam logic [CW-1:0] SHORT_LAST = CW'(CLK_PER_US - 1);
   localparam logic [CW-1:0] LONG_LAST  = CW'(3 * CLK_PER_US - 1);

   logic [CW-1:0] phase;
   logic [CW-1:0] low_last;

   always_comb begin
      low_last  = (stop || bit_val) ? SHORT_LAST : LONG_LAST;
      cell_end  = run && (phase == (stop ? SHORT_LAST : LAST_CELL));
      // Every cell opens low, so the cycle after a cell end is always low.
      low_phase = cell_end || (phase < low_last);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phase <= '0;
      end else if (!run || cell_end) begin
         phase <= '0;
      end else begin
         phase <= phase + 1'b1;
      end
   end

endmodule

// File: rtl/joybus_tx.sv
// Joybus command transmitter: shifts out 1-24 command bits MSB-first as bit cells,
// followed by a stop bit, on an open-drain data line with registered outputs.
module joybus_tx
   import joybus_pkg::*;
#(
   parameter int unsigned CLK_PER_US = 50
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [23:0] cmd_data,
   input  logic [4:0]  cmd_len,
   output logic        line_out,
   output logic        line_oe,
   output logic        busy,
   output logic        done
);

   state_t      state;
   logic [23:0] shreg;
   logic [4:0]  bit_cnt;
   logic        run;
   logic        in_stop;
   logic        low_phase;
   logic        cell_end;

   assign run     = (state != IDLE);
   assign in_stop = (state == STOP);

   joybus_bit_timer #(
      .CLK_PER_US(CLK_PER_US)
   ) u_timer (
      .clock    (clock),
      .reset    (reset),
      .run      (run),
      .bit_val  (shreg[23]),
      .stop     (in_stop),
      .low_phase(low_phase),
      .cell_end (cell_end)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         line_out <= 1'b1;
         line_oe  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && len_ok(cmd_len)) begin
                  shreg    <= cmd_data;
                  bit_cnt  <= cmd_len;
                  state    <= DATA;
                  line_out <= 1'b0;
                  line_oe  <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            DATA: begin
               line_out <= ~low_phase;
               if (cell_end) begin
                  shreg <= {shreg[22:0], 1'b0};
                  if (bit_cnt != 5'd0) begin
                     bit_cnt <= bit_cnt - 5'd1;
                  end
                  if (bit_cnt == 5'd1) begin
                     state <= STOP;
                  end
               end
            end
            STOP: begin
               if (cell_end) begin
                  state    <= IDLE;
                  line_out <= 1'b1;
                  line_oe  <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  line_out <= ~low_phase;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
